// File: rtl/scp_pkg.sv
// -----------------------------------------------------------------------------
// scp_pkg
//   Shared types and constants for the SCP instruction fetch stage.
//   - state_e    : fetch/sequencing FSM states
//   - OPC_*      : opcode field position inside the 32-bit instruction word
//   - INSTR_W    : instruction word width
//   - CNT_W      : width of the retired-instruction counter
//   - sat_inc()  : saturating increment for the retired-instruction counter
// -----------------------------------------------------------------------------
package scp_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_e;

    localparam int OPC_W   = 3;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 29;
    localparam int INSTR_W = 32;

    localparam int                CNT_W   = 16;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    // Counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + CNT_W'(1);
    endfunction

endpackage : scp_pkg

// File: rtl/scp_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// scp_fetch_unit_if
//   Instruction memory read port (request/acknowledge).
//   - mem_req   : read request, held until acknowledged
//   - mem_addr  : fetch address (program counter)
//   - mem_ack   : read data valid this cycle
//   - mem_rdata : 32-bit instruction word
//   Modports: master = fetch unit side, slave = memory side.
// -----------------------------------------------------------------------------
interface scp_fetch_unit_if #(
    parameter int ADDR_W = 8
);
    import scp_pkg::*;

    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_ack;
    logic [INSTR_W-1:0]  mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface : scp_fetch_unit_if

// File: rtl/scp_fetch_watchdog.sv
// -----------------------------------------------------------------------------
// scp_fetch_watchdog
//   Counts cycles spent waiting for a memory acknowledge and raises a
//   one-cycle timeout when the wait reaches MAX_WAIT cycles.
//   Ports:
//   - clk     : clock, rising edge
//   - reset   : synchronous active-high reset
//   - clear   : zero the count (takes priority over enable)
//   - enable  : a waiting cycle with no acknowledge; counts it
//   - timeout : high in the MAX_WAIT-th consecutive enabled cycle
//   Parameter MAX_WAIT: 1..255.
// -----------------------------------------------------------------------------
module scp_fetch_watchdog #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int              WD_W     = 8;
    localparam logic [WD_W-1:0] WAIT_LST = WD_W'(MAX_WAIT - 1);

    logic [WD_W-1:0] count_q;
    logic [WD_W-1:0] count_d;

    always_comb begin
        // NOTE: every variable gets its default first so no path leaves it unassigned and no latch is inferred.
        count_d = count_q;
        timeout = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            // The count equals the number of waiting cycles already elapsed,
            // so the cycle that finds MAX_WAIT-1 is the MAX_WAIT-th one.
            timeout = (count_q == WAIT_LST);
            count_d = count_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values together.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : scp_fetch_watchdog

// File: rtl/scp_fetch_unit.sv
// -----------------------------------------------------------------------------
// scp_fetch_unit
//   Instruction fetch and sequencing stage of the single-cycle accumulator
//   processor. Owns the PC, fetches instruction words over a req/ack port,
//   holds them in the IR for the controller/datapath and advances, jumps or
//   halts once the datapath reports completion.
//   Ports:
//   - clk, reset   : clock and synchronous active-high reset
//   - mem          : instruction memory port (master side)
//   - opCode       : IR[31:29], to the controller
//   - operand      : IR[ADDR_W-1:0], memory/IO address or jump target
//   - ir_valid     : IR holds the instruction being executed
//   - exec_done    : datapath finished the current instruction
//   - jump_req     : with exec_done, next PC = operand
//   - halt_req     : with exec_done, stop after this instruction
//   - halted       : unit is halted (leave only via reset)
//   - fetch_err    : sticky, set when a fetch is not acknowledged in time
//   - instr_count  : retired instructions, saturating
// -----------------------------------------------------------------------------
module scp_fetch_unit
    import scp_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0,
    parameter int MAX_WAIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    scp_fetch_unit_if.master     mem,
    output logic [OPC_W-1:0]     opCode,
    output logic [ADDR_W-1:0]    operand,
    output logic                 ir_valid,
    input  logic                 exec_done,
    input  logic                 jump_req,
    input  logic                 halt_req,
    output logic                 halted,
    output logic                 fetch_err,
    output logic [CNT_W-1:0]     instr_count
);

    localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

    state_e               state_q,     state_d;
    logic [ADDR_W-1:0]    pc_q,        pc_d;
    logic [INSTR_W-1:0]   ir_q,        ir_d;
    logic [CNT_W-1:0]     count_q,     count_d;
    logic                 fetch_err_q, fetch_err_d;
    logic                 mem_req_q,   mem_req_d;
    logic                 ir_valid_q,  ir_valid_d;
    logic                 halted_q,    halted_d;

    logic                 fetch_active;
    logic                 wd_clear;
    logic                 wd_enable;
    logic                 wd_timeout;
    logic                 unused_ir_bits;

    // The request is registered, so the first cycle out of reset sits in
    // FETCH with mem_req still low. Only cycles that actually present a
    // request may accept an acknowledge or count towards the timeout.
    assign fetch_active = (state_q == FETCH) && mem_req_q;

    // Cleared whenever no request is outstanding, so each FETCH entry
    // starts the wait from zero.
    assign wd_clear  = !fetch_active;
    assign wd_enable = fetch_active && !mem.mem_ack;

    scp_fetch_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .timeout (wd_timeout)
    );

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        count_d     = count_q;
        fetch_err_d = fetch_err_q;

        unique case (state_q)
            FETCH: begin
                // An acknowledge wins over a timeout in the same cycle.
                if (fetch_active) begin
                    if (mem.mem_ack) begin
                        ir_d    = mem.mem_rdata;
                        state_d = EXEC;
                    end else if (wd_timeout) begin
                        fetch_err_d = 1'b1;
                        state_d     = HALT;
                    end
                end
            end

            EXEC: begin
                if (exec_done) begin
                    count_d = sat_inc(count_q);
                    // Halt wins over jump; a halted PC keeps pointing at the
                    // instruction that requested the halt.
                    if (halt_req) begin
                        state_d = HALT;
                    end else if (jump_req) begin
                        pc_d    = ir_q[ADDR_W-1:0];
                        state_d = FETCH;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
            end

            HALT: begin
                state_d = HALT;
            end

            default: begin
                state_d = FETCH;
            end
        endcase

        // Control outputs are registered from the next state so every
        // output is a clean flop and matches the state it describes.
        mem_req_d  = (state_d == FETCH);
        ir_valid_d = (state_d == EXEC);
        halted_d   = (state_d == HALT);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC_V;
            ir_q        <= '0;
            count_q     <= '0;
            fetch_err_q <= 1'b0;
            mem_req_q   <= 1'b0;
            ir_valid_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            count_q     <= count_d;
            fetch_err_q <= fetch_err_d;
            mem_req_q   <= mem_req_d;
            ir_valid_q  <= ir_valid_d;
            halted_q    <= halted_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = pc_q;

    // opCode/operand come straight from the IR, so they only move on an IR
    // load and stay stable for the whole EXEC phase.
    assign opCode      = ir_q[OPC_MSB:OPC_LSB];
    assign operand     = ir_q[ADDR_W-1:0];
    assign ir_valid    = ir_valid_q;
    assign halted      = halted_q;
    assign fetch_err   = fetch_err_q;
    assign instr_count = count_q;

    // The middle instruction bits are held in the IR as part of the fetched
    // word but are not decoded by this stage.
    assign unused_ir_bits = ^ir_q[OPC_LSB-1:ADDR_W];

endmodule : scp_fetch_unit

// File: tb/tb_scp_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_scp_fetch_unit
//   Self-checking bench for scp_fetch_unit (ADDR_W=8, RESET_PC=0, MAX_WAIT=4).
//   A hand-written vector table walks the directed scenarios, then random
//   stimulus is compared cycle by cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_scp_fetch_unit;

    localparam int ADDR_W   = 8;
    localparam int MAX_WAIT = 4;
    localparam int OUT_W    = 39;

    logic              clk = 1'b0;
    logic              reset;
    logic              exec_done;
    logic              jump_req;
    logic              halt_req;
    logic [2:0]        opCode;
    logic [ADDR_W-1:0] operand;
    logic              ir_valid;
    logic              halted;
    logic              fetch_err;
    logic [15:0]       instr_count;

    scp_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

    scp_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (0),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem         (bus),
        .opCode      (opCode),
        .operand     (operand),
        .ir_valid    (ir_valid),
        .exec_done   (exec_done),
        .jump_req    (jump_req),
        .halt_req    (halt_req),
        .halted      (halted),
        .fetch_err   (fetch_err),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic [OUT_W-1:0] pack_out(
        input logic req, input logic [7:0] addr, input logic [2:0] opc,
        input logic [7:0] opnd, input logic valid, input logic hlt,
        input logic err, input logic [15:0] cnt);
        return {req, addr, opc, opnd, valid, hlt, err, cnt};
    endfunction

    function automatic logic [OUT_W-1:0] dut_out();
        return pack_out(bus.mem_req, bus.mem_addr, opCode, operand,
                        ir_valid, halted, fetch_err, instr_count);
    endfunction

    task automatic check(input string name, input logic [OUT_W-1:0] act,
                         input logic [OUT_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got {req,addr,opc,opnd,valid,halted,err,cnt}=%h required %h",
                     name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic ack, input logic [31:0] rdata,
                         input logic done, input logic jmp, input logic hlt);
        reset         = rst;
        bus.mem_ack   = ack;
        bus.mem_rdata = rdata;
        exec_done     = done;
        jump_req      = jmp;
        halt_req      = hlt;
    endtask

    // -------------------------------------------------------------------------
    // Directed vector table: inputs for one cycle, outputs after that edge
    // -------------------------------------------------------------------------
    typedef struct {
        logic              rst;
        logic              ack;
        logic [31:0]       rdata;
        logic              done;
        logic              jmp;
        logic              hlt;
        logic [OUT_W-1:0]  exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, input logic ack, input logic [31:0] rdata,
        input logic done, input logic jmp, input logic hlt,
        input logic req, input logic [7:0] addr, input logic [2:0] opc,
        input logic [7:0] opnd, input logic valid, input logic hl,
        input logic err, input logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.ack = ack; v.rdata = rdata;
        v.done = done; v.jmp = jmp; v.hlt = hlt;
        v.exp = pack_out(req, addr, opc, opnd, valid, hl, err, cnt);
        return v;
    endfunction

    task automatic build_table();
        // reset, first request, IR=A0000005 held while exec_done is late
        tbl.push_back(mk(1,0,32'h0,0,0,0,          0,8'h00,3'd0,8'h00,0,0,0,16'd0));
        tbl.push_back(mk(0,0,32'h0,0,0,0,          1,8'h00,3'd0,8'h00,0,0,0,16'd0));
        tbl.push_back(mk(0,1,32'hA000_0005,0,0,0,  0,8'h00,3'd5,8'h05,1,0,0,16'd0));
        tbl.push_back(mk(0,0,32'h0,0,0,0,          0,8'h00,3'd5,8'h05,1,0,0,16'd0));
        tbl.push_back(mk(0,0,32'h0,0,0,0,          0,8'h00,3'd5,8'h05,1,0,0,16'd0));
        tbl.push_back(mk(0,0,32'h0,1,0,0,          1,8'h01,3'd5,8'h05,0,0,0,16'd1));
        // jump to 0x40
        tbl.push_back(mk(0,1,32'h2000_0040,0,0,0,  0,8'h01,3'd1,8'h40,1,0,0,16'd1));
        tbl.push_back(mk(0,0,32'h0,1,1,0,          1,8'h40,3'd1,8'h40,0,0,0,16'd2));
        // jump to 0xFF, then plain advance wraps to 0x00
        tbl.push_back(mk(0,1,32'h0000_00FF,0,0,0,  0,8'h40,3'd0,8'hFF,1,0,0,16'd2));
        tbl.push_back(mk(0,0,32'h0,1,1,0,          1,8'hFF,3'd0,8'hFF,0,0,0,16'd3));
        tbl.push_back(mk(0,1,32'h4000_0011,0,0,0,  0,8'hFF,3'd2,8'h11,1,0,0,16'd3));
        tbl.push_back(mk(0,0,32'h0,1,0,0,          1,8'h00,3'd2,8'h11,0,0,0,16'd4));
        // halt and jump together: halt wins, PC kept, later inputs ignored
        tbl.push_back(mk(0,1,32'hE000_0022,0,0,0,  0,8'h00,3'd7,8'h22,1,0,0,16'd4));
        tbl.push_back(mk(0,0,32'h0,1,1,1,          0,8'h00,3'd7,8'h22,0,1,0,16'd5));
        tbl.push_back(mk(0,1,32'h1234_5678,1,1,0,  0,8'h00,3'd7,8'h22,0,1,0,16'd5));
        tbl.push_back(mk(0,1,32'h1234_5678,1,0,0,  0,8'h00,3'd7,8'h22,0,1,0,16'd5));
        // timeout: no ack, halted + fetch_err exactly MAX_WAIT cycles after entry
        tbl.push_back(mk(1,0,32'h0,0,0,0,          0,8'h00,3'd0,8'h00,0,0,0,16'd0));
        tbl.push_back(mk(0,0,32'h0,0,0,0,          1,8'h00,3'd0,8'h00,0,0,0,16'd0));
        tbl.push_back(mk(0,0,32'h0,0,0,0,          1,8'h00,3'd0,8'h00,0,0,0,16'd0));
        tbl.push_back(mk(0,0,32'h0,0,0,0,          1,8'h00,3'd0,8'h00,0,0,0,16'd0));
        tbl.push_back(mk(0,0,32'h0,0,0,0,          1,8'h00,3'd0,8'h00,0,0,0,16'd0));
        tbl.push_back(mk(0,0,32'h0,0,0,0,          0,8'h00,3'd0,8'h00,0,1,1,16'd0));
        // ack on the last allowed cycle is accepted without error
        tbl.push_back(mk(1,0,32'h0,0,0,0,          0,8'h00,3'd0,8'h00,0,0,0,16'd0));
        tbl.push_back(mk(0,0,32'h0,0,0,0,          1,8'h00,3'd0,8'h00,0,0,0,16'd0));
        tbl.push_back(mk(0,0,32'h0,0,0,0,          1,8'h00,3'd0,8'h00,0,0,0,16'd0));
        tbl.push_back(mk(0,0,32'h0,0,0,0,          1,8'h00,3'd0,8'h00,0,0,0,16'd0));
        tbl.push_back(mk(0,0,32'h0,0,0,0,          1,8'h00,3'd0,8'h00,0,0,0,16'd0));
        tbl.push_back(mk(0,1,32'h2000_0003,0,0,0,  0,8'h00,3'd1,8'h03,1,0,0,16'd0));
        tbl.push_back(mk(0,0,32'h0,1,0,0,          1,8'h01,3'd1,8'h03,0,0,0,16'd1));
        // reset mid-fetch with a response pending
        tbl.push_back(mk(0,0,32'h0,0,0,0,          1,8'h01,3'd1,8'h03,0,0,0,16'd1));
        tbl.push_back(mk(1,1,32'hFFFF_FFFF,0,0,0,  0,8'h00,3'd0,8'h00,0,0,0,16'd0));
        tbl.push_back(mk(0,0,32'h0,0,0,0,          1,8'h00,3'd0,8'h00,0,0,0,16'd0));
        // ack and exec_done tied high: two cycles per instruction
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0)
                tbl.push_back(mk(0,1,32'h0,1,0,0, 0,8'(k/2),3'd0,8'h00,1,0,0,16'(k/2)));
            else
                tbl.push_back(mk(0,1,32'h0,1,0,0, 1,8'((k+1)/2),3'd0,8'h00,0,0,0,16'((k+1)/2)));
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model: one call per rising edge with that cycle's inputs
    // -------------------------------------------------------------------------
    typedef enum int {M_IDLE, M_FETCH, M_EXEC, M_HALT} mmode_e;

    mmode_e      m_mode;
    int          m_pc;
    int          m_wait;
    int          m_cnt;
    logic [31:0] m_ir;
    logic        m_err;

    task automatic model_edge(input logic rst, input logic ack, input logic [31:0] rdata,
                              input logic done, input logic jmp, input logic hlt);
        if (rst) begin
            m_mode = M_IDLE; m_pc = 0; m_wait = 0; m_cnt = 0; m_ir = '0; m_err = 1'b0;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                m_mode = M_FETCH;
                m_wait = 0;
            end
            M_FETCH: begin
                if (ack) begin
                    m_ir   = rdata;
                    m_mode = M_EXEC;
                end else if (m_wait == MAX_WAIT - 1) begin
                    m_err  = 1'b1;
                    m_mode = M_HALT;
                end else begin
                    m_wait++;
                end
            end
            M_EXEC: begin
                if (done) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (hlt) begin
                        m_mode = M_HALT;
                    end else begin
                        m_pc   = jmp ? int'(m_ir[7:0]) : (m_pc + 1) % 256;
                        m_mode = M_FETCH;
                        m_wait = 0;
                    end
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [OUT_W-1:0] model_out();
        return pack_out(m_mode == M_FETCH, 8'(m_pc), m_ir[31:29], m_ir[7:0],
                        m_mode == M_EXEC, m_mode == M_HALT, m_err, 16'(m_cnt));
    endfunction

    // -------------------------------------------------------------------------
    // Test sequence
    // -------------------------------------------------------------------------
    initial begin
        logic        r_rst, r_ack, r_done, r_jmp, r_hlt;
        logic [31:0] r_rdata;

        drive(1, 0, 32'h0, 0, 0, 0);
        build_table();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].ack, tbl[i].rdata, tbl[i].done, tbl[i].jmp, tbl[i].hlt);
            @(posedge clk);
            #1;
            check($sformatf("vec[%0d]", i), dut_out(), tbl[i].exp);
        end

        drive(1, 0, 32'h0, 0, 0, 0);
        @(posedge clk);
        model_edge(1, 0, 32'h0, 0, 0, 0);
        #1;
        check("rand_reset", dut_out(), model_out());

        for (int i = 0; i < 800; i++) begin
            r_rst   = ($urandom_range(0, 99) < 2) ||
                      (m_mode == M_HALT && $urandom_range(0, 7) == 0);
            r_ack   = ($urandom_range(0, 99) < 45);
            r_rdata = $urandom;
            r_done  = ($urandom_range(0, 2) == 0);
            r_jmp   = 1'($urandom_range(0, 1));
            r_hlt   = ($urandom_range(0, 15) == 0);
            drive(r_rst, r_ack, r_rdata, r_done, r_jmp, r_hlt);
            @(posedge clk);
            model_edge(r_rst, r_ack, r_rdata, r_done, r_jmp, r_hlt);
            #1;
            check($sformatf("rand[%0d]", i), dut_out(), model_out());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_scp_fetch_unit
